traffic_sensor_front: RTL and testbench

Front-end conditioning stage that feeds the intersection light controller. It divides the system clock into the one-cycle `tick` strobe the controller advances on. It also synchronises and debounces the NS vehicle-loop sensor and converts each debounced arrival into a single `extension` pulse aligned to `tick`. Extensions are issued only while NS is green and are capped per green phase, so the controller cannot stretch NS green indefinitely.

---
 rtl/traffic_sensor_front_if.sv | 26 ++
 rtl/traffic_sensor_front.sv | 102 ++++++++++
 tb/tb_traffic_sensor_front.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/traffic_sensor_front_if.sv
// Sensor front-end signal bundle: controller feedback in, tick/extension strobes out.
// Latency: none, wires only.
// Backpressure: none; strobes are free-running.
interface traffic_sensor_front_if #(
  parameter int MAX_EXT = 2
);
  localparam int EW = $clog2(MAX_EXT + 1);

  logic          sensor_raw;
  logic          ns_green;
  logic          tick;
  logic          extension;
  logic          sensor_level;
  logic          req_pending;
  logic [EW-1:0] ext_count;

  modport master (
    input  sensor_raw, ns_green,
    output tick, extension, sensor_level, req_pending, ext_count
  );

  modport slave (
    output sensor_raw, ns_green,
    input  tick, extension, sensor_level, req_pending, ext_count
  );
endinterface

// File: rtl/traffic_sensor_front.sv
// Tick prescaler plus debounced NS-loop sensor turned into capped, tick-aligned extensions.
// Latency: sensor_raw to sensor_level 2+DB_CYCLES clocks; grant at the next tick edge.
// Backpressure: none; requests beyond MAX_EXT per green phase wait until green ends.
module traffic_sensor_front #(
  parameter int CLK_DIV   = 1000,
  parameter int DB_CYCLES = 16,
  parameter int MAX_EXT   = 2
) (
  input  logic                   clk,
  input  logic                   reset,
  traffic_sensor_front_if.master bus
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int BW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int EW = $clog2(MAX_EXT + 1);

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [BW-1:0] DB_LAST  = BW'(DB_CYCLES - 1);
  localparam logic [EW-1:0] EXT_MAX  = EW'(MAX_EXT);

  logic [DW-1:0] div_cnt;
  logic          tick_q;
  logic          ext_q;
  logic          sync_a;
  logic          sensor_sync;
  logic [BW-1:0] db_cnt;
  logic          level_q;
  logic          level_d;
  logic          pend_q;
  logic [EW-1:0] cnt_q;

  logic tick_edge;
  logic rise;
  logic grant;

  assign tick_edge = (div_cnt == DIV_LAST);
  assign rise      = level_q & ~level_d;
  assign grant     = tick_edge & pend_q & bus.ns_green & (cnt_q < EXT_MAX);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      tick_q  <= 1'b0;
    end else begin
      div_cnt <= tick_edge ? '0 : div_cnt + DW'(1);
      tick_q  <= tick_edge;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_a      <= 1'b0;
      sensor_sync <= 1'b0;
    end else begin
      sync_a      <= bus.sensor_raw;
      sensor_sync <= sync_a;
    end
  end

  // Any clock agreeing with the accepted level restarts the hold count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      db_cnt  <= '0;
      level_q <= 1'b0;
      level_d <= 1'b0;
    end else begin
      level_d <= level_q;
      if (sensor_sync == level_q) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        level_q <= sensor_sync;
        db_cnt  <= '0;
      end else begin
        db_cnt <= db_cnt + BW'(1);
      end
    end
  end

  // Leaving NS green wipes the phase; a fresh arrival outranks the grant's clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_q <= 1'b0;
      cnt_q  <= '0;
      ext_q  <= 1'b0;
    end else begin
      ext_q <= grant;
      if (!bus.ns_green) begin
        pend_q <= 1'b0;
        cnt_q  <= '0;
      end else begin
        pend_q <= rise | (pend_q & ~grant);
        if (grant) cnt_q <= cnt_q + EW'(1);
      end
    end
  end

  assign bus.tick         = tick_q;
  assign bus.extension    = ext_q;
  assign bus.sensor_level = level_q;
  assign bus.req_pending  = pend_q;
  assign bus.ext_count    = cnt_q;
endmodule

// File: tb/tb_traffic_sensor_front.sv
// Bench for traffic_sensor_front: directed scenarios then a randomized soak, every cycle
// compared against a reference model built from edge counts and sensor sample history.
module tb_traffic_sensor_front;
  localparam int CLK_DIV   = 4;
  localparam int DB_CYCLES = 3;
  localparam int MAX_EXT   = 2;
  localparam int MAXC      = 8192;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  traffic_sensor_front_if #(.MAX_EXT(MAX_EXT)) bus ();

  traffic_sensor_front #(
    .CLK_DIV  (CLK_DIV),
    .DB_CYCLES(DB_CYCLES),
    .MAX_EXT  (MAX_EXT)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: edge index since reset release, raw samples and level per edge.
  int cyc;
  bit rawh [MAXC];
  bit lvlb [MAXC];
  bit m_level, m_rose, m_pend, m_tick, m_ext;
  int m_cnt;

  // Value the debouncer compares at edge k: raw as sampled two edges earlier.
  function automatic bit seen(input int k);
    return (k >= 3) ? rawh[k-2] : 1'b0;
  endfunction

  task automatic model_reset();
    cyc     = 0;
    m_level = 0;
    m_rose  = 0;
    m_pend  = 0;
    m_tick  = 0;
    m_ext   = 0;
    m_cnt   = 0;
  endtask

  task automatic model_step();
    bit g, set, old, ok, grant;
    g = bus.ns_green;
    cyc++;
    rawh[cyc] = bus.sensor_raw;
    lvlb[cyc] = m_level;
    set = m_rose && g;
    old = m_level;
    // Accept a new level once the last DB_CYCLES compared samples all disagreed with a steady level.
    if (cyc >= DB_CYCLES) begin
      ok = 1;
      for (int j = cyc - DB_CYCLES + 1; j <= cyc; j++)
        if (seen(j) == lvlb[j] || lvlb[j] != lvlb[cyc]) ok = 0;
      if (ok) m_level = !m_level;
    end
    m_rose = m_level && !old;
    m_tick = (cyc % CLK_DIV) == 0;
    grant  = m_tick && m_pend && g && (m_cnt < MAX_EXT);
    m_ext  = grant;
    if (!g) begin
      m_pend = 0;
      m_cnt  = 0;
    end else begin
      if (grant) m_cnt++;
      m_pend = set || (m_pend && !grant);
    end
  endtask

  task automatic check_outputs();
    chk("tick", bus.tick, m_tick);
    chk("extension", bus.extension, m_ext);
    chk("sensor_level", bus.sensor_level, m_level);
    chk("req_pending", bus.req_pending, m_pend);
    chk("ext_count", bus.ext_count, m_cnt);
    chk("ext_without_tick", bus.extension & ~bus.tick, 0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_tick"}, bus.tick, 0);
    chk({tag, "_extension"}, bus.extension, 0);
    chk({tag, "_level"}, bus.sensor_level, 0);
    chk({tag, "_pending"}, bus.req_pending, 0);
    chk({tag, "_count"}, bus.ext_count, 0);
  endtask

  task automatic step(input bit r, input bit g);
    bus.sensor_raw = r;
    bus.ns_green   = g;
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int hold);
    @(posedge clk);
    #2 reset = 1'b1;
    #1 check_zero("rst_async");
    repeat (hold) @(negedge clk);
    check_zero("rst_hold");
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int  left_g, left_r, waited;
    bit  g, r;
    bus.sensor_raw = 1'b0;
    bus.ns_green   = 1'b0;
    repeat (3) @(negedge clk);
    check_zero("rst_init");
    reset = 1'b0;
    model_reset();

    // Divider alone
    repeat (20) step(0, 0);

    // Bouncing arrival during green, then release
    step(1, 1); step(0, 1); step(1, 1); step(0, 1);
    repeat (12) step(1, 1);
    repeat (10) step(0, 1);

    // Three arrivals in one green phase: cap at MAX_EXT, third left pending
    repeat (3) begin
      repeat (6) step(1, 1);
      repeat (6) step(0, 1);
    end
    repeat (8) step(0, 1);
    repeat (2) step(0, 0);

    // Arrival while red is discarded
    repeat (6) step(1, 0);
    repeat (12) step(0, 0);

    // One grant, then a second request, then reset shortly after it latches
    repeat (6) step(1, 1);
    repeat (6) step(0, 1);
    waited = 0;
    while (bus.req_pending !== 1'b1 && waited < 20) begin
      step(1, 1);
      waited++;
    end
    chk("pend_before_reset", bus.req_pending, 1);
    chk("count_before_reset", bus.ext_count, 1);
    step(1, 1); step(1, 1);
    do_reset(2);
    repeat (8) step(1, 1);
    repeat (8) step(0, 1);

    // Randomized soak with bouncing sensor, random green phases and occasional resets
    left_g = 0;
    left_r = 0;
    g = 0;
    r = 0;
    for (int i = 0; i < 3000; i++) begin
      if (left_g == 0) begin
        g      = ($urandom_range(0, 3) != 0);
        left_g = $urandom_range(15, 60);
      end
      if (left_r == 0) begin
        r      = ~r;
        left_r = $urandom_range(1, 10);
      end
      left_g--;
      left_r--;
      step(r, g);
      if (i % 900 == 899) do_reset(2);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
